// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - score word field layout and sequencer state encoding
package score_pkg;

  localparam int PITCH_MSB = 11;
  localparam int PITCH_LSB = 8;
  localparam int OCT_MSB   = 7;
  localparam int OCT_LSB   = 5;
  localparam int DUR_MSB   = 4;
  localparam int DUR_LSB   = 0;

  localparam logic [3:0] PITCH_REST = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP
  } state_t;

endpackage

// File: rtl/score_player_note_timer.sv
// rtl/score_player_note_timer.sv - counts dur x UNIT_TICKS non-paused cycles of one note
module note_timer
  import score_pkg::*;
#(
  parameter int UNIT_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] dur,
  input  logic       pause,
  output logic       done
);

  localparam int UW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

  logic [UW-1:0] unit_cnt;
  logic [4:0]    rem_cnt;
  logic          unit_last;

  assign unit_last = (unit_cnt == UW'(UNIT_TICKS - 1));
  // High in the final counted cycle so the sequencer leaves PLAY on that edge.
  assign done = !load && !pause && unit_last && (rem_cnt == 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_cnt <= '0;
      rem_cnt  <= '0;
    end else if (load) begin
      unit_cnt <= '0;
      rem_cnt  <= dur;
    end else if (!pause && rem_cnt != 5'd0) begin
      if (unit_last) begin
        unit_cnt <= '0;
        rem_cnt  <= rem_cnt - 5'd1;
      end else begin
        unit_cnt <= unit_cnt + UW'(1);
      end
    end
  end

endmodule

// File: rtl/score_player.sv
// rtl/score_player.sv - fetches score entries and drives the tone generator
module score_player
  import score_pkg::*;
#(
  parameter int UNIT_TICKS = 4,
  parameter int GAP_TICKS  = 1,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              note_valid,
  output logic [3:0]        note_pitch,
  output logic [2:0]        note_octave,
  output logic              note_start,
  output logic              busy,
  output logic              done
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] len_q;
  logic [3:0]        pitch_q;
  logic [2:0]        oct_q;
  logic              note_start_q;
  logic              done_q;
  logic [GW-1:0]     gap_cnt;
  logic              timer_done;
  logic [4:0]        fetch_dur;

  state_t            adv_state;
  logic [ADDR_W-1:0] adv_idx;
  logic              adv_done;
  logic              last_entry;

  assign fetch_dur = rd_data[DUR_MSB:DUR_LSB];

  note_timer #(.UNIT_TICKS(UNIT_TICKS)) u_note_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == FETCH),
    .dur   (fetch_dur),
    .pause (pause || state != PLAY),
    .done  (timer_done)
  );

  // Widened compare so idx+1 cannot wrap when len_q is at its maximum.
  assign last_entry = ({1'b0, idx} + {{ADDR_W{1'b0}}, 1'b1}) >= {1'b0, len_q};

  always_comb begin
    adv_state = FETCH;
    adv_idx   = idx + ADDR_W'(1);
    adv_done  = 1'b0;
    if (last_entry) begin
      if (loop_en) begin
        adv_idx = '0;
      end else begin
        adv_state = IDLE;
        adv_idx   = idx;
        adv_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      len_q        <= '0;
      pitch_q      <= '0;
      oct_q        <= '0;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_q <= song_len;
              idx   <= '0;
              if (song_len == '0) begin
                done_q <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end
          end
          FETCH: begin
            pitch_q <= rd_data[PITCH_MSB:PITCH_LSB];
            oct_q   <= rd_data[OCT_MSB:OCT_LSB];
            if (fetch_dur == 5'd0) begin
              state  <= adv_state;
              idx    <= adv_idx;
              done_q <= adv_done;
            end else begin
              state        <= PLAY;
              note_start_q <= 1'b1;
            end
          end
          PLAY: begin
            if (timer_done) begin
              if (GAP_TICKS == 0) begin
                state  <= adv_state;
                idx    <= adv_idx;
                done_q <= adv_done;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end
          end
          GAP: begin
            if (!pause) begin
              if (gap_cnt == GAP_LAST) begin
                state  <= adv_state;
                idx    <= adv_idx;
                done_q <= adv_done;
              end else begin
                gap_cnt <= gap_cnt + GW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rd_addr     = idx;
  assign busy        = (state != IDLE);
  assign note_valid  = (state == PLAY) && !pause && (pitch_q != PITCH_REST);
  assign note_pitch  = pitch_q;
  assign note_octave = oct_q;
  assign note_start  = note_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_score_player.sv
// tb/tb_score_player.sv - directed self-checking bench for score_player
module tb_score_player;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, pause, loop_en;
  logic [15:0] song_len;
  logic [15:0] rd_addr;
  logic [11:0] rd_data;
  logic        note_valid;
  logic [3:0]  note_pitch;
  logic [2:0]  note_octave;
  logic        note_start;
  logic        busy;
  logic        done;

  logic [11:0] mem [0:7];
  int checks = 0;
  int failures = 0;
  int ns_cnt;
  int done_cnt;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr[2:0]];

  score_player #(.UNIT_TICKS(4), .GAP_TICKS(1), .ADDR_W(16), .DATA_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .loop_en     (loop_en),
    .song_len    (song_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .note_valid  (note_valid),
    .note_pitch  (note_pitch),
    .note_octave (note_octave),
    .note_start  (note_start),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [11:0] ent(input int p, input int o, input int d);
    ent = {p[3:0], o[2:0], d[4:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop  = with_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; pause = 0; loop_en = 0; song_len = 0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    #23;
    chk("rst_valid", note_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_pitch", note_pitch, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // 1: two notes with gap
    mem[0] = ent(6, 2, 4); mem[1] = ent(9, 2, 2); song_len = 2;
    pulse_start(1'b0);
    for (int c = 1; c <= 30; c++) begin
      chk($sformatf("t1_valid_c%0d", c), note_valid, ((c >= 2 && c <= 17) || (c >= 20 && c <= 27)) ? 1 : 0);
      chk($sformatf("t1_start_c%0d", c), note_start, (c == 2 || c == 20) ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", c), busy, (c <= 28) ? 1 : 0);
      chk($sformatf("t1_done_c%0d", c), done, (c == 29) ? 1 : 0);
      if (c == 1)  chk("t1_addr0", rd_addr, 0);
      if (c == 19) chk("t1_addr1", rd_addr, 1);
      if (c == 10) begin chk("t1_pitch0", note_pitch, 6); chk("t1_oct0", note_octave, 2); end
      if (c == 24) chk("t1_pitch1", note_pitch, 9);
      if (c == 30) chk("t1_pitch_hold", note_pitch, 9);
      tick();
    end

    // 2: rest entry
    mem[0] = ent(0, 2, 4); song_len = 1;
    pulse_start(1'b0);
    for (int c = 1; c <= 20; c++) begin
      chk($sformatf("t2_valid_c%0d", c), note_valid, 0);
      chk($sformatf("t2_start_c%0d", c), note_start, (c == 2) ? 1 : 0);
      chk($sformatf("t2_done_c%0d", c), done, (c == 19) ? 1 : 0);
      tick();
    end

    // 3: zero-duration entry skipped
    mem[0] = ent(0, 2, 0); mem[1] = ent(4, 1, 2); song_len = 2;
    pulse_start(1'b0);
    ns_cnt = 0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 1) chk("t3_addr_c1", rd_addr, 0);
      if (c == 2) chk("t3_addr_c2", rd_addr, 1);
      if (c == 5) begin chk("t3_pitch", note_pitch, 4); chk("t3_oct", note_octave, 1); end
      if (note_start) ns_cnt++;
      chk($sformatf("t3_valid_c%0d", c), note_valid, (c >= 3 && c <= 10) ? 1 : 0);
      chk($sformatf("t3_done_c%0d", c), done, (c == 12) ? 1 : 0);
      tick();
    end
    chk("t3_start_count", ns_cnt, 1);

    // 4: loop then stop
    mem[0] = ent(7, 2, 1); song_len = 1; loop_en = 1;
    pulse_start(1'b0);
    ns_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 22; c++) begin
      chk($sformatf("t4_start_c%0d", c), note_start, (c % 6 == 2) ? 1 : 0);
      if (note_start) ns_cnt++;
      if (done) done_cnt++;
      tick();
    end
    chk("t4_start_count", ns_cnt, 4);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_playing", note_valid, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 0;
    chk("t4_stop_busy", busy, 0);
    chk("t4_stop_valid", note_valid, 0);
    chk("t4_stop_done", done, 0);
    tick();
    chk("t4_stop_done2", done, 0);

    // 5: pause mid-note
    mem[0] = ent(5, 3, 4); song_len = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      pause = (c >= 5 && c <= 9);
      #1;
      chk($sformatf("t5_valid_c%0d", c), note_valid, (c >= 2 && c <= 22 && !(c >= 5 && c <= 9)) ? 1 : 0);
      chk($sformatf("t5_done_c%0d", c), done, (c == 24) ? 1 : 0);
      if (c == 7) chk("t5_pitch_hold", note_pitch, 5);
      tick();
    end
    pause = 0;

    // 6: empty song, start+stop, async reset
    song_len = 0;
    pulse_start(1'b0);
    chk("t6_len0_done", done, 1);
    chk("t6_len0_busy", busy, 0);
    chk("t6_len0_addr", rd_addr, 0);
    tick();
    chk("t6_len0_done_once", done, 0);
    song_len = 1;
    pulse_start(1'b1);
    chk("t6_startstop_busy", busy, 0);
    chk("t6_startstop_done", done, 0);
    pulse_start(1'b0);
    tick();
    tick();
    chk("t6_pre_reset_valid", note_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", note_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pitch", note_pitch, 0);
    chk("t6_rst_oct", note_octave, 0);
    chk("t6_rst_addr", rd_addr, 0);
    chk("t6_rst_start", note_start, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_rst_done", done, 0);
    chk("t6_post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
